// File: rtl/ddr_bw_pkg.sv
// Shared types and constants for the DDR bandwidth-test sequencer.
// Includes the state encoding, the min/max record and the expected-beat helper.
package ddr_bw_pkg;

    localparam int unsigned DEF_BURST_LENGTH = 7;
    localparam int unsigned BEATS_PER_BURST  = DEF_BURST_LENGTH + 1;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE    = 3'd0;
    localparam seq_state_t ST_ARM     = 3'd1;
    localparam seq_state_t ST_RUN     = 3'd2;
    localparam seq_state_t ST_RELEASE = 3'd3;
    localparam seq_state_t ST_CHECK   = 3'd4;
    localparam seq_state_t ST_DONE    = 3'd5;

    typedef struct packed {
        logic        have_job;
        logic [31:0] min_cyc;
        logic [31:0] max_cyc;
    } stat_t;

    function automatic logic [47:0] calc_exp_beats(input logic [31:0] nburst,
                                                   input int unsigned burst_length);
        return 48'(nburst) * 48'(burst_length + 1);
    endfunction

endpackage

// File: rtl/ddr_bw_stats.sv
// Per-sequence job statistics: saturating total cycle count plus min/max job latency.
// The first completed job loads both min and max; later jobs compare unsigned.
module ddr_bw_stats
    import ddr_bw_pkg::*;
#(
    parameter int TOT_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd,
    input  logic [31:0]      job_cyc,
    output logic [TOT_W-1:0] total_cyc,
    output logic [31:0]      min_cyc,
    output logic [31:0]      max_cyc
);

    stat_t            st;
    logic [TOT_W:0]   sum;
    logic [TOT_W-1:0] total_nxt;

    assign sum       = {1'b0, total_cyc} + (TOT_W+1)'(job_cyc);
    assign total_nxt = sum[TOT_W] ? '1 : sum[TOT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            st        <= '0;
            total_cyc <= '0;
        end else if (upd) begin
            total_cyc   <= total_nxt;
            st.have_job <= 1'b1;
            if (!st.have_job || job_cyc < st.min_cyc) st.min_cyc <= job_cyc;
            if (!st.have_job || job_cyc > st.max_cyc) st.max_cyc <= job_cyc;
        end
    end

    assign min_cyc = st.min_cyc;
    assign max_cyc = st.max_cyc;

endmodule

// File: rtl/ddr_bw_seq_ctrl.sv
// Sequencer for the DDR bandwidth-test AXI read master: runs back-to-back read jobs,
// times each one, counts drained beats and reports statistics and error flags.
//
// state   | meaning
// IDLE    | waiting for a cfg_start rising edge
// ARM     | address/nburst presented, beat counter cleared, start still low
// RUN     | mst_start high, job cycle counter running until mst_done
// RELEASE | start dropped, wait for done to clear and all beats drained
// CHECK   | record job stats, check beat count, step the address
// DONE    | sequence finished, results held until the next start
module ddr_bw_seq_ctrl
    import ddr_bw_pkg::*;
#(
    parameter int unsigned BURST_LENGTH = DEF_BURST_LENGTH,
    parameter int          RUN_W        = 16,
    parameter int          TOT_W        = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [31:0]      cfg_base_addr,
    input  logic [31:0]      cfg_stride,
    input  logic [31:0]      cfg_nburst,
    input  logic [RUN_W-1:0] cfg_nruns,
    input  logic [31:0]      cfg_timeout,
    output logic             mst_start,
    output logic [31:0]      mst_addr,
    output logic [31:0]      mst_nburst,
    input  logic             mst_done,
    input  logic             beat_valid,
    input  logic             beat_ready,
    output logic             stat_busy,
    output logic             stat_done,
    output logic             stat_err_timeout,
    output logic             stat_err_beats,
    output logic [RUN_W-1:0] stat_runs_done,
    output logic [TOT_W-1:0] stat_total_cyc,
    output logic [31:0]      stat_min_cyc,
    output logic [31:0]      stat_max_cyc
);

    seq_state_t       state;
    logic             start_q;
    logic             start_edge;
    logic             seq_accept;
    logic [31:0]      stride_q;
    logic [RUN_W-1:0] nruns_q;
    logic [47:0]      exp_beats;
    logic [47:0]      beat_cnt;
    logic             beat_carry;
    logic             beat;
    logic [31:0]      cyc;
    logic [31:0]      ph_cnt;
    logic [31:0]      ph_nxt;
    logic             tmo_hit;
    logic             release_ok;
    logic             last_run;

    assign start_edge = cfg_start && !start_q;
    assign seq_accept = start_edge && (state == ST_IDLE || state == ST_DONE);
    assign beat       = beat_valid && beat_ready;
    assign ph_nxt     = ph_cnt + 32'd1;
    assign tmo_hit    = (cfg_timeout != 32'd0) && (ph_nxt >= cfg_timeout);
    assign release_ok = !mst_done && (beat_cnt >= exp_beats);
    assign last_run   = (stat_runs_done + RUN_W'(1)) == nruns_q;

    // Decoded from state and gated by rst so the master sees start drop in the reset cycle itself.
    assign mst_start  = (state == ST_RUN) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            start_q          <= 1'b0;
            stride_q         <= '0;
            nruns_q          <= '0;
            exp_beats        <= '0;
            beat_cnt         <= '0;
            beat_carry       <= 1'b0;
            cyc              <= '0;
            ph_cnt           <= '0;
            mst_addr         <= '0;
            mst_nburst       <= '0;
            stat_busy        <= 1'b0;
            stat_done        <= 1'b0;
            stat_err_timeout <= 1'b0;
            stat_err_beats   <= 1'b0;
            stat_runs_done   <= '0;
        end else begin
            start_q <= cfg_start;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (seq_accept) begin
                        mst_addr         <= cfg_base_addr;
                        mst_nburst       <= cfg_nburst;
                        stride_q         <= cfg_stride;
                        nruns_q          <= cfg_nruns;
                        exp_beats        <= calc_exp_beats(cfg_nburst, BURST_LENGTH);
                        beat_carry       <= 1'b0;
                        stat_err_timeout <= 1'b0;
                        stat_err_beats   <= 1'b0;
                        stat_runs_done   <= '0;
                        stat_busy        <= (cfg_nruns != '0);
                        stat_done        <= (cfg_nruns == '0);
                        state            <= (cfg_nruns == '0) ? ST_DONE : ST_ARM;
                    end
                end
                ST_ARM: begin
                    beat_cnt   <= {47'd0, beat_carry};
                    beat_carry <= 1'b0;
                    cyc        <= 32'd1;
                    ph_cnt     <= '0;
                    state      <= ST_RUN;
                end
                ST_RUN: begin
                    if (beat) beat_cnt <= beat_cnt + 48'd1;
                    if (mst_done) begin
                        ph_cnt <= '0;
                        state  <= ST_RELEASE;
                    end else if (tmo_hit) begin
                        stat_err_timeout <= 1'b1;
                        stat_busy        <= 1'b0;
                        stat_done        <= 1'b1;
                        state            <= ST_DONE;
                    end else begin
                        cyc    <= cyc + 32'd1;
                        ph_cnt <= ph_nxt;
                    end
                end
                ST_RELEASE: begin
                    if (beat) beat_cnt <= beat_cnt + 48'd1;
                    if (release_ok) begin
                        state <= ST_CHECK;
                    end else if (tmo_hit) begin
                        stat_err_timeout <= 1'b1;
                        stat_busy        <= 1'b0;
                        stat_done        <= 1'b1;
                        state            <= ST_DONE;
                    end else begin
                        ph_cnt <= ph_nxt;
                    end
                end
                ST_CHECK: begin
                    // A beat arriving here belongs to the next job.
                    beat_carry     <= beat;
                    if (beat_cnt != exp_beats) stat_err_beats <= 1'b1;
                    stat_runs_done <= stat_runs_done + RUN_W'(1);
                    mst_addr       <= mst_addr + stride_q;
                    if (last_run) begin
                        stat_busy <= 1'b0;
                        stat_done <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        state <= ST_ARM;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ddr_bw_stats #(
        .TOT_W (TOT_W)
    ) u_stats (
        .clk       (clk),
        .rst       (rst),
        .clr       (seq_accept),
        .upd       (state == ST_CHECK),
        .job_cyc   (cyc),
        .total_cyc (stat_total_cyc),
        .min_cyc   (stat_min_cyc),
        .max_cyc   (stat_max_cyc)
    );

endmodule

// File: tb/tb_ddr_bw_seq_ctrl.sv
// Self-checking bench for ddr_bw_seq_ctrl with a behavioural read-master/sink model.
// Job addresses are queued as expected when a sequence is configured and popped on each start.
module tb_ddr_bw_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [31:0] cfg_base_addr;
    logic [31:0] cfg_stride;
    logic [31:0] cfg_nburst;
    logic [15:0] cfg_nruns;
    logic [31:0] cfg_timeout;
    logic        mst_start;
    logic [31:0] mst_addr;
    logic [31:0] mst_nburst;
    logic        mst_done;
    logic        beat_valid;
    logic        beat_ready;
    logic        stat_busy;
    logic        stat_done;
    logic        stat_err_timeout;
    logic        stat_err_beats;
    logic [15:0] stat_runs_done;
    logic [47:0] stat_total_cyc;
    logic [31:0] stat_min_cyc;
    logic [31:0] stat_max_cyc;

    ddr_bw_seq_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_start        (cfg_start),
        .cfg_base_addr    (cfg_base_addr),
        .cfg_stride       (cfg_stride),
        .cfg_nburst       (cfg_nburst),
        .cfg_nruns        (cfg_nruns),
        .cfg_timeout      (cfg_timeout),
        .mst_start        (mst_start),
        .mst_addr         (mst_addr),
        .mst_nburst       (mst_nburst),
        .mst_done         (mst_done),
        .beat_valid       (beat_valid),
        .beat_ready       (beat_ready),
        .stat_busy        (stat_busy),
        .stat_done        (stat_done),
        .stat_err_timeout (stat_err_timeout),
        .stat_err_beats   (stat_err_beats),
        .stat_runs_done   (stat_runs_done),
        .stat_total_cyc   (stat_total_cyc),
        .stat_min_cyc     (stat_min_cyc),
        .stat_max_cyc     (stat_max_cyc)
    );

    always #5 clk = ~clk;

    // Master model: done rises after lat start-sampling edges, so RUN lasts lat+1 cycles.
    int unsigned lat_a   [0:7];
    int unsigned beats_a [0:7];
    logic        tb_clr;
    logic [2:0]  job_idx;
    int unsigned cur_lat;
    int unsigned lat_cnt;
    int unsigned beats_left;
    logic        start_d;

    assign beat_valid = (beats_left != 0);

    always @(posedge clk) begin
        start_d <= mst_start;
        if (rst || tb_clr) begin
            job_idx    <= '0;
            beats_left <= 0;
        end else if (mst_start && !start_d) begin
            beats_left <= beats_a[job_idx];
            cur_lat    <= lat_a[job_idx];
            job_idx    <= job_idx + 3'd1;
        end else if (beats_left != 0 && beat_ready) begin
            beats_left <= beats_left - 1;
        end
        if (rst || !mst_start) begin
            lat_cnt  <= 0;
            mst_done <= 1'b0;
        end else if (!mst_done) begin
            lat_cnt <= lat_cnt + 1;
            if (lat_cnt + 1 == cur_lat) mst_done <= 1'b1;
        end
    end

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_nburst;
    logic        prev_start = 1'b0;
    int          rises = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic watch_cycle();
        logic [31:0] e;
        @(negedge clk);
        if (mst_start && !prev_start) begin
            rises++;
            if (exp_addr_q.size() == 0) begin
                check_val("unexpected_job", 64'(mst_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_addr_q.pop_front();
                check_val("mst_addr", 64'(mst_addr), 64'(e));
                check_val("mst_nburst", 64'(mst_nburst), 64'(exp_nburst));
            end
        end
        prev_start = mst_start;
    endtask

    task automatic start_seq(input logic [31:0] base, input logic [31:0] stride,
                             input logic [31:0] nburst, input logic [15:0] nruns,
                             input logic [31:0] tmo, input int n_jobs_started);
        @(negedge clk);
        tb_clr        = 1'b1;
        cfg_base_addr = base;
        cfg_stride    = stride;
        cfg_nburst    = nburst;
        cfg_nruns     = nruns;
        cfg_timeout   = tmo;
        exp_nburst    = nburst;
        rises         = 0;
        for (int k = 0; k < n_jobs_started; k++) exp_addr_q.push_back(base + 32'(k) * stride);
        @(negedge clk);
        tb_clr    = 1'b0;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start  = 1'b0;
        prev_start = mst_start;
    endtask

    task automatic run_seq(input string tag, input int bound);
        int n = 0;
        while (!stat_done && n < bound) begin
            watch_cycle();
            n++;
        end
        if (n >= bound) check_val({tag, "_bound"}, 64'(stat_done), 64'd1);
        check_val({tag, "_addr_left"}, 64'(exp_addr_q.size()), 64'd0);
        exp_addr_q.delete();
    endtask

    task automatic check_stats(input string tag, input int runs, input longint total,
                               input int mn, input int mx, input logic et, input logic eb);
        check_val({tag, "_busy"},    64'(stat_busy), 64'd0);
        check_val({tag, "_done"},    64'(stat_done), 64'd1);
        check_val({tag, "_runs"},    64'(stat_runs_done), 64'(runs));
        check_val({tag, "_total"},   64'(stat_total_cyc), 64'(total));
        check_val({tag, "_min"},     64'(stat_min_cyc), 64'(mn));
        check_val({tag, "_max"},     64'(stat_max_cyc), 64'(mx));
        check_val({tag, "_err_tmo"}, 64'(stat_err_timeout), 64'(et));
        check_val({tag, "_err_bts"}, 64'(stat_err_beats), 64'(eb));
    endtask

    task automatic set_jobs(input int unsigned l0, input int unsigned l1,
                            input int unsigned l2, input int unsigned l3,
                            input int unsigned b0, input int unsigned b1,
                            input int unsigned b2, input int unsigned b3);
        lat_a[0] = l0; lat_a[1] = l1; lat_a[2] = l2; lat_a[3] = l3;
        beats_a[0] = b0; beats_a[1] = b1; beats_a[2] = b2; beats_a[3] = b3;
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        tb_clr        = 1'b0;
        cfg_start     = 1'b0;
        cfg_base_addr = '0;
        cfg_stride    = '0;
        cfg_nburst    = '0;
        cfg_nruns     = '0;
        cfg_timeout   = '0;
        beat_ready    = 1'b1;
        exp_nburst    = '0;
        for (int k = 0; k < 8; k++) begin
            lat_a[k]   = 100;
            beats_a[k] = 128;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_val("rst_start",  64'(mst_start), 64'd0);
        check_val("rst_addr",   64'(mst_addr), 64'd0);
        check_val("rst_nburst", 64'(mst_nburst), 64'd0);
        check_val("rst_busy",   64'(stat_busy), 64'd0);
        check_val("rst_done",   64'(stat_done), 64'd0);
        check_val("rst_total",  64'(stat_total_cyc), 64'd0);

        // 1: four equal jobs, 16 bursts x 8 beats each
        set_jobs(100, 100, 100, 100, 128, 128, 128, 128);
        start_seq(32'h1000_0000, 32'h400, 32'd16, 16'd4, 32'd0, 4);
        check_val("t1_busy_run", 64'(stat_busy), 64'd1);
        run_seq("t1", 2000);
        check_stats("t1", 4, 404, 101, 101, 1'b0, 1'b0);
        check_val("t1_last_addr", 64'(mst_addr), 64'h1000_1000);

        // 2: varied latencies
        set_jobs(50, 80, 60, 70, 128, 128, 128, 128);
        start_seq(32'h2000_0000, 32'h1000, 32'd16, 16'd4, 32'd1000, 4);
        run_seq("t2", 2000);
        check_stats("t2", 4, 264, 51, 81, 1'b0, 1'b0);

        // 3: one beat missing in job 2 stalls RELEASE until the timeout
        set_jobs(100, 100, 100, 100, 128, 127, 128, 128);
        start_seq(32'h1000_0000, 32'h400, 32'd16, 16'd4, 32'd1000, 2);
        run_seq("t3", 4000);
        check_stats("t3", 1, 101, 101, 101, 1'b1, 1'b0);

        // 4: an extra beat in job 1 flags the error but the sequence completes
        set_jobs(100, 100, 100, 100, 129, 128, 128, 128);
        start_seq(32'h1000_0000, 32'h400, 32'd16, 16'd4, 32'd1000, 4);
        run_seq("t4", 2000);
        check_stats("t4", 4, 404, 101, 101, 1'b0, 1'b1);

        // 5: zero runs goes straight to DONE
        start_seq(32'h3000_0000, 32'h400, 32'd16, 16'd0, 32'd0, 0);
        check_stats("t5", 0, 0, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) watch_cycle();
        check_val("t5_no_start", 64'(rises), 64'd0);

        // 6: reset in the middle of job 2
        set_jobs(100, 100, 100, 100, 128, 128, 128, 128);
        start_seq(32'h1000_0000, 32'h400, 32'd16, 16'd4, 32'd0, 2);
        n = 0;
        while (rises < 2 && n < 500) begin
            watch_cycle();
            n++;
        end
        check_val("t6_reach_job2", 64'(rises), 64'd2);
        repeat (5) watch_cycle();
        check_val("t6_start_pre", 64'(mst_start), 64'd1);
        rst = 1'b1;
        #1;
        check_val("t6_start_in_rst", 64'(mst_start), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check_val("t6_start_after", 64'(mst_start), 64'd0);
        check_val("t6_busy",  64'(stat_busy), 64'd0);
        check_val("t6_runs",  64'(stat_runs_done), 64'd0);
        check_val("t6_total", 64'(stat_total_cyc), 64'd0);
        check_val("t6_min",   64'(stat_min_cyc), 64'd0);
        check_val("t6_max",   64'(stat_max_cyc), 64'd0);
        check_val("t6_addr",  64'(mst_addr), 64'd0);
        exp_addr_q.delete();
        prev_start = mst_start;

        // 6b: address wraps past 32 bits without error
        start_seq(32'hFFFF_FC00, 32'h400, 32'd16, 16'd2, 32'd0, 2);
        run_seq("t6b", 1000);
        check_stats("t6b", 2, 202, 101, 101, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
